icache_direct_mapped: RTL and testbench
=======================================

# icache_direct_mapped

Parametrised direct-mapped instruction cache between the fetch stage and instruction memory. Fetch presents `pc`; a hit returns the instruction combinationally in the same cycle, and a miss stalls fetch while a refill state machine loads one full line over a valid/ready memory interface. It supports line invalidation via `flush` and a bypass-off enable.

## Interface
- `NUM_LINES`, 16: number of cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥2.
- `ADDR_W`, 32: byte-address width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc` in ADDR_W: fetch byte address; bits [1:0] ignored.
- `instr_cache_enable` in 1: fetch request this cycle.
- `flush` in 1: invalidate all lines (e.g. after `fence.i`).
- `instr_out` out 32: fetched instruction; valid only while `instr_valid`.
- `instr_valid` out 1: hit on the current `pc` this cycle.
- `instr_cache_processing` out 1: stall to fetch; miss or refill in progress.
- `mem_req_valid` out 1: line-refill request.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out ADDR_W: line-aligned base byte address.
- `mem_rsp_valid` in 1: one refill word present.
- `mem_rsp_data` in 32: refill word; beats arrive in ascending word order.

## Operation
- Address split: offset = `pc[2 +: OFF_W]`, index = next `IDX_W` bits, tag = remaining upper bits. `OFF_W` = log2(WORDS_PER_LINE) and `IDX_W` = log2(NUM_LINES).
- Storage: per line, one valid bit, one tag register, and a data array of WORDS_PER_LINE×32.
- FSM states:
  - IDLE: if `instr_cache_enable`, valid bit set, and tag match, then `instr_valid`=1 and `instr_out` = data[index][offset]. If `instr_cache_enable` misses, latch tag/index, clear that line's valid bit, and go to REQ.
  - REQ: hold `mem_req_valid`=1 and `mem_req_addr` = {tag, index, zeros} stable until `mem_req_ready`. Then go to FILL with beat counter = 0.
  - FILL: each `mem_rsp_valid` writes `mem_rsp_data` to data[index][counter] and increments the counter. On the beat where counter = WORDS_PER_LINE−1, write the tag, set the valid bit, and go to IDLE.
- `instr_cache_processing` = 1 in REQ and FILL, and in the IDLE miss cycle.
- `instr_valid`=0 whenever `instr_cache_processing`=1 or `instr_cache_enable`=0. `instr_out` is then don't-care; the implementation drives 0.
- `flush` in IDLE clears all valid bits at the clock edge. A same-cycle hit is still reported.
- `flush` during REQ/FILL clears all valid bits immediately and sets a sticky `abort` flag. The refill completes its handshake, but the line is not marked valid.
- A `pc` change during REQ/FILL is ignored; the latched address is refilled.
- Memory responses outside FILL are ignored.

## Timing
- Reset values: all valid bits 0, FSM = IDLE, beat counter 0, `mem_req_valid`=0, `instr_valid`=0, `instr_cache_processing`=0, `instr_out`=0. Tag and data arrays are not reset.
- Hit latency: 0 cycles, with combinational output from `pc`.
- Miss penalty: 1 (IDLE→REQ) + request-wait cycles + WORDS_PER_LINE response beats. The hit occurs in the first IDLE cycle after the last beat, assuming the same `pc`.
- `mem_req_valid` rises the cycle after the miss and drops the cycle after the `mem_req_ready` handshake.
- `rst` mid-refill returns to IDLE at the next edge. Outstanding memory beats are then ignored.

## Structure
- Shared package `icache_pkg` holds the FSM state enum (`IC_IDLE`, `IC_REQ`, `IC_FILL`) and the localparam helpers for `OFF_W`, `IDX_W`, and `TAG_W`.
- One natural sub-module: `icache_tag_data_array`. It holds the valid/tag/data storage with a combinational read port, a single word write port, a tag-set port, and flash valid clear.
- The top level holds the FSM, address split, and handshakes.

## Test plan
- Cold miss: after reset, `pc`=0x100 with enable. Expect `instr_cache_processing`=1, then `mem_req_addr`=0x100. Drive 4 beats 0xA0..0xA3. Next cycle `instr_valid`=1 with `instr_out`=0xA0.
- Hits across the line: `pc`=0x104, 0x108, 0x10C give 0xA1, 0xA2, 0xA3 in consecutive cycles with no stall.
- Conflict eviction: with the default parameters, `pc`=0x500 maps to the same index as 0x100 and causes a miss. After it refills, `pc`=0x100 misses again.
- Backpressure: hold `mem_req_ready`=0 for 5 cycles and insert gaps between response beats. `mem_req_addr` must stay stable, and the data must be correct.
- Flush: assert `flush` mid-FILL. After the fill, 0x100 misses again. `flush` in IDLE makes every previously cached line miss.
- Reset mid-FILL: assert `rst` after 2 beats. Expect IDLE, all outputs at their reset values, and `pc`=0x100 misses again.

Source files
------------

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared types and address-split helpers for the direct-mapped
//               instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_REQ  = 2'd1,
        IC_FILL = 2'd2
    } ic_state_t;

    localparam int c_WORD_W = 32;

    function automatic int off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Byte-offset bits [1:0] sit below the word offset and never reach the tag.
    function automatic int tag_w(input int addr_w, input int num_lines, input int words_per_line);
        return addr_w - 2 - $clog2(num_lines) - $clog2(words_per_line);
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_if
// Description : Fetch-side and refill-memory signals of the instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              instr_cache_enable;
    logic              flush;
    logic [31:0]       instr_out;
    logic              instr_valid;
    logic              instr_cache_processing;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rsp_data;

    // master is the cache itself; slave is the fetch stage plus memory.
    modport master (
        input  pc, instr_cache_enable, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output instr_out, instr_valid, instr_cache_processing, mem_req_valid, mem_req_addr
    );

    modport slave (
        output pc, instr_cache_enable, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  instr_out, instr_valid, instr_cache_processing, mem_req_valid, mem_req_addr
    );
endinterface
`default_nettype wire

// File: rtl/icache_tag_data_array.sv
`default_nettype none
// ============================================================================
// Module      : icache_tag_data_array
// Description : Valid/tag/data storage with combinational read, one word write
//               port, tag-set port, single-line invalidate and flash clear.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_tag_data_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 24
) (
    input  wire logic                            clk,
    input  wire logic                            rst,
    input  wire logic [idx_w(NUM_LINES)-1:0]      i_rd_idx,
    input  wire logic [off_w(WORDS_PER_LINE)-1:0] i_rd_off,
    output logic                                 o_rd_valid,
    output logic [TAG_W-1:0]                     o_rd_tag,
    output logic [31:0]                          o_rd_data,
    input  wire logic                            i_wr_en,
    input  wire logic [idx_w(NUM_LINES)-1:0]      i_wr_idx,
    input  wire logic [off_w(WORDS_PER_LINE)-1:0] i_wr_off,
    input  wire logic [31:0]                     i_wr_data,
    input  wire logic                            i_set_en,
    input  wire logic [idx_w(NUM_LINES)-1:0]      i_set_idx,
    input  wire logic [TAG_W-1:0]                i_set_tag,
    input  wire logic                            i_inv_en,
    input  wire logic [idx_w(NUM_LINES)-1:0]      i_inv_idx,
    input  wire logic                            i_flash_clr
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag_mem  [NUM_LINES];
    logic [31:0]          r_data_mem [NUM_LINES][WORDS_PER_LINE];

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag_mem[i_rd_idx];
    assign o_rd_data  = r_data_mem[i_rd_idx][i_rd_off];

    // Flash clear dominates so a flush can never be undone by a same-edge set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_flash_clr) begin
            r_valid <= '0;
        end else begin
            if (i_inv_en) begin
                r_valid[i_inv_idx] <= 1'b0;
            end
            if (i_set_en) begin
                r_valid[i_set_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_set_en) begin
            r_tag_mem[i_set_idx] <= i_set_tag;
        end
        if (i_wr_en) begin
            r_data_mem[i_wr_idx][i_wr_off] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module      : icache_direct_mapped
// Description : Direct-mapped instruction cache with zero-latency hits and a
//               single-line refill FSM over a valid/ready memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_direct_mapped
    import icache_pkg::*;
#(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    icache_if.master  bus
);

    localparam int c_OFF_W = off_w(WORDS_PER_LINE);
    localparam int c_IDX_W = idx_w(NUM_LINES);
    localparam int c_TAG_W = tag_w(ADDR_W, NUM_LINES, WORDS_PER_LINE);
    localparam logic [c_OFF_W-1:0] c_LAST_BEAT = c_OFF_W'(WORDS_PER_LINE - 1);

    ic_state_t          r_state;
    logic [c_TAG_W-1:0] r_tag;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_OFF_W-1:0] r_cnt;
    logic               r_abort;
    logic               r_mem_req_valid;

    logic [c_OFF_W-1:0] w_off;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_rd_valid;
    logic [c_TAG_W-1:0] w_rd_tag;
    logic [31:0]        w_rd_data;
    logic               w_idle;
    logic               w_hit;
    logic               w_miss;
    logic               w_beat;
    logic               w_last;
    logic               w_unused_pc_bits;

    assign w_off            = bus.pc[2 +: c_OFF_W];
    assign w_idx            = bus.pc[2 + c_OFF_W +: c_IDX_W];
    assign w_tag            = bus.pc[ADDR_W-1 -: c_TAG_W];
    assign w_unused_pc_bits = ^bus.pc[1:0];

    assign w_idle = (r_state == IC_IDLE);
    assign w_hit  = w_idle && bus.instr_cache_enable && w_rd_valid && (w_rd_tag == w_tag);
    assign w_miss = w_idle && bus.instr_cache_enable && !(w_rd_valid && (w_rd_tag == w_tag));
    assign w_beat = (r_state == IC_FILL) && bus.mem_rsp_valid;
    assign w_last = w_beat && (r_cnt == c_LAST_BEAT);

    assign bus.instr_valid            = w_hit;
    assign bus.instr_out              = w_hit ? w_rd_data : 32'd0;
    assign bus.instr_cache_processing = !w_idle || w_miss;
    assign bus.mem_req_valid          = r_mem_req_valid;
    assign bus.mem_req_addr           = {r_tag, r_idx, {(c_OFF_W + 2){1'b0}}};

    icache_tag_data_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (c_TAG_W)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx    (w_idx),
        .i_rd_off    (w_off),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_data   (w_rd_data),
        .i_wr_en     (w_beat),
        .i_wr_idx    (r_idx),
        .i_wr_off    (r_cnt),
        .i_wr_data   (bus.mem_rsp_data),
        // A flush seen on the final beat counts as an abort too.
        .i_set_en    (w_last && !r_abort && !bus.flush),
        .i_set_idx   (r_idx),
        .i_set_tag   (r_tag),
        .i_inv_en    (w_miss),
        .i_inv_idx   (w_idx),
        .i_flash_clr (bus.flush)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IC_IDLE;
            r_tag           <= '0;
            r_idx           <= '0;
            r_cnt           <= '0;
            r_abort         <= 1'b0;
            r_mem_req_valid <= 1'b0;
        end else begin
            case (r_state)
                IC_IDLE: begin
                    if (w_miss) begin
                        r_tag           <= w_tag;
                        r_idx           <= w_idx;
                        r_abort         <= 1'b0;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= IC_REQ;
                    end
                end
                IC_REQ: begin
                    if (bus.flush) begin
                        r_abort <= 1'b1;
                    end
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= IC_FILL;
                    end
                end
                IC_FILL: begin
                    if (bus.flush) begin
                        r_abort <= 1'b1;
                    end
                    if (w_beat) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= IC_IDLE;
                    end
                end
                default: begin
                    r_state         <= IC_IDLE;
                    r_mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_direct_mapped
// Description : Scoreboard bench for icache_direct_mapped with a memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_direct_mapped;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_if #(.ADDR_W(32)) bus ();

    logic main_flush = 1'b0;
    logic resp_flush = 1'b0;
    assign bus.flush = main_flush | resp_flush;

    icache_direct_mapped #(
        .NUM_LINES      (16),
        .WORDS_PER_LINE (4),
        .ADDR_W         (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] data_q [$];
    logic [31:0] req_q  [$];

    int req_wait   = 0;
    int beat_gap   = 0;
    int beat_limit = 4;
    int flush_hs   = -1;
    int hs_count   = 0;
    int beats_sent = 0;

    function automatic logic [31:0] data_for(input logic [31:0] a);
        if (a[31:4] == 28'h000_0010) return 32'hA0 + {30'd0, a[3:2]};
        return {8'hC0, a[23:0]};
    endfunction

    // Memory model: accepts one line request, then streams four beats.
    initial begin : responder
        int          rstate;
        int          wcnt;
        int          gcnt;
        int          beat;
        bit          first;
        logic [31:0] cap;
        logic [31:0] exp_addr;
        rstate = 0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = 32'd0;
            resp_flush        = 1'b0;
            if (rst) begin
                rstate = 0;
                continue;
            end
            if (rstate == 0 && bus.mem_req_valid === 1'b1) begin
                cap    = bus.mem_req_addr;
                wcnt   = 0;
                rstate = 1;
                checks++;
                if (req_q.size() == 0) begin
                    errors++;
                    $display("FAIL req_addr: unexpected request 0x%08h", cap);
                end else begin
                    exp_addr = req_q.pop_front();
                    if (cap !== exp_addr) begin
                        errors++;
                        $display("FAIL req_addr: got 0x%08h expected 0x%08h", cap, exp_addr);
                    end
                end
            end
            if (rstate == 1) begin
                if (wcnt > 0) begin
                    checks++;
                    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== cap) begin
                        errors++;
                        $display("FAIL req_stable: valid %b addr 0x%08h expected 1 0x%08h",
                                 bus.mem_req_valid, bus.mem_req_addr, cap);
                    end
                end
                if (wcnt >= req_wait) begin
                    bus.mem_req_ready = 1'b1;
                    hs_count++;
                    rstate = 2;
                    gcnt   = 0;
                    beat   = 0;
                    first  = 1'b1;
                end else begin
                    wcnt++;
                end
            end else if (rstate == 2) begin
                if (first) begin
                    first = 1'b0;
                    checks++;
                    if (bus.mem_req_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL req_drop: mem_req_valid %b expected 0", bus.mem_req_valid);
                    end
                end
                if (gcnt >= beat_gap) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = data_for(cap + 32'(4 * beat));
                    if (hs_count == flush_hs && beat == 2) resp_flush = 1'b1;
                    beat++;
                    beats_sent++;
                    gcnt = 0;
                    if (beat >= beat_limit) rstate = 0;
                end else begin
                    gcnt++;
                end
            end
        end
    end

    // Fetch one pc, expecting n_miss refills before the hit; exp_lat < 0 skips timing.
    task automatic fetch(input logic [31:0] addr, input int n_miss, input int exp_lat);
        int          lat;
        bit          got;
        logic [31:0] exp;
        @(negedge clk);
        bus.pc                 = addr;
        bus.instr_cache_enable = 1'b1;
        data_q.push_back(data_for(addr));
        for (int i = 0; i < n_miss; i++) req_q.push_back({addr[31:4], 4'h0});
        #1;
        checks++;
        if (bus.instr_cache_processing !== (n_miss > 0) ||
            (n_miss > 0 && (bus.instr_valid !== 1'b0 || bus.instr_out !== 32'd0))) begin
            errors++;
            $display("FAIL first_cycle pc 0x%08h: processing %b valid %b out 0x%08h expected processing %0d",
                     addr, bus.instr_cache_processing, bus.instr_valid, bus.instr_out, n_miss > 0);
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 400) begin
            if (bus.instr_valid === 1'b1) got = 1'b1;
            else begin
                @(negedge clk);
                #1;
                lat++;
            end
        end
        checks++;
        exp = data_q.pop_front();
        if (!got) begin
            errors++;
            $display("FAIL hit_timeout pc 0x%08h: no instr_valid, expected 0x%08h", addr, exp);
        end else if (bus.instr_out !== exp) begin
            errors++;
            $display("FAIL instr_out pc 0x%08h: got 0x%08h expected 0x%08h", addr, bus.instr_out, exp);
        end
        if (exp_lat >= 0) begin
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL latency pc 0x%08h: got %0d expected %0d", addr, lat, exp_lat);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.instr_cache_processing !== 1'b0 ||
            bus.mem_req_valid !== 1'b0 || bus.instr_out !== 32'd0) begin
            errors++;
            $display("FAIL %s: valid %b processing %b req %b out 0x%08h expected 0 0 0 0",
                     name, bus.instr_valid, bus.instr_cache_processing, bus.mem_req_valid, bus.instr_out);
        end
    endtask

    task automatic test_reset();
        bus.pc                 = 32'd0;
        bus.instr_cache_enable = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("reset_state");
    endtask

    task automatic test_cold_miss();
        fetch(32'h100, 1, 6);
    endtask

    task automatic test_hits();
        fetch(32'h104, 0, 0);
        fetch(32'h108, 0, 0);
        fetch(32'h10C, 0, 0);
        fetch(32'h100, 0, 0);
    endtask

    task automatic test_conflict();
        fetch(32'h500, 1, 6);
        fetch(32'h50C, 0, 0);
        fetch(32'h100, 1, 6);
    endtask

    task automatic test_backpressure();
        req_wait = 5;
        beat_gap = 2;
        fetch(32'h240, 1, 19);
        req_wait = 0;
        beat_gap = 0;
        fetch(32'h244, 0, 0);
        fetch(32'h24C, 0, 0);
    endtask

    task automatic test_flush_fill();
        int hs0;
        fetch(32'h500, 1, 6);
        hs0      = hs_count;
        flush_hs = hs_count + 1;
        fetch(32'h100, 2, -1);
        flush_hs = -1;
        checks++;
        if (hs_count - hs0 != 2) begin
            errors++;
            $display("FAIL flush_refetch: refills %0d expected 2", hs_count - hs0);
        end
        fetch(32'h104, 0, 0);
    endtask

    task automatic test_flush_idle();
        logic [31:0] exp;
        fetch(32'h140, 1, 6);
        @(negedge clk);
        bus.pc     = 32'h100;
        main_flush = 1'b1;
        data_q.push_back(data_for(32'h100));
        #1;
        exp = data_q.pop_front();
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_out !== exp) begin
            errors++;
            $display("FAIL flush_same_cycle_hit: valid %b out 0x%08h expected 1 0x%08h",
                     bus.instr_valid, bus.instr_out, exp);
        end
        @(negedge clk);
        main_flush = 1'b0;
        bus.instr_cache_enable = 1'b0;
        fetch(32'h100, 1, 6);
        fetch(32'h140, 1, 6);
    endtask

    task automatic test_reset_mid_fill();
        int b0;
        int n;
        fetch(32'h500, 1, 6);
        @(negedge clk);
        beat_limit = 2;
        b0 = beats_sent;
        bus.pc = 32'h100;
        bus.instr_cache_enable = 1'b1;
        req_q.push_back(32'h100);
        n = 0;
        while (beats_sent < b0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (beats_sent < b0 + 2) begin
            errors++;
            $display("FAIL partial_fill: beats %0d expected 2", beats_sent - b0);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.instr_cache_enable = 1'b0;
        beat_limit = 4;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("reset_mid_fill");
        fetch(32'h100, 1, 6);
        fetch(32'h10C, 0, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_hits();
        test_conflict();
        test_backpressure();
        test_flush_fill();
        test_flush_idle();
        test_reset_mid_fill();
        @(negedge clk);
        checks++;
        if (req_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_req: %0d pending expected 0", req_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
